// File: rtl/jtgng_vtimer.sv
// Video timing generator for the 6 MHz pixel domain: pixel counters, blanking
// strobes and native syncs, all advancing on cen6 pulses of a single clock.
module jtgng_vtimer #(
    parameter int HACTIVE  = 256,
    parameter int HTOTAL   = 384,
    parameter int HS_START = 288,
    parameter int HS_LEN   = 32,
    parameter int VACTIVE  = 224,
    parameter int VTOTAL   = 262,
    parameter int VS_START = 240,
    parameter int VS_LEN   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen6,
    input  logic       flip,
    output logic [8:0] H,
    output logic [8:0] V,
    output logic       LHBL,
    output logic       LVBL,
    output logic       HS,
    output logic       VS,
    output logic       hinit,
    output logic       vinit,
    output logic       frame
);

    // Bounds are held at 10 bits so HS_START+HS_LEN == 512 still compares correctly
    localparam logic [9:0] H_LAST  = 10'(HTOTAL - 1);
    localparam logic [9:0] V_LAST  = 10'(VTOTAL - 1);
    localparam logic [9:0] H_ACT   = 10'(HACTIVE);
    localparam logic [9:0] V_ACT   = 10'(VACTIVE);
    localparam logic [9:0] HS_BEG  = 10'(HS_START);
    localparam logic [9:0] HS_END  = 10'(HS_START + HS_LEN);
    localparam logic [9:0] VS_BEG  = 10'(VS_START);
    localparam logic [9:0] VS_END  = 10'(VS_START + VS_LEN);

    if (HS_START + HS_LEN > HTOTAL) begin : g_bad_hs
        $error("jtgng_vtimer: HS_START+HS_LEN must not exceed HTOTAL");
    end
    if (VS_START + VS_LEN > VTOTAL) begin : g_bad_vs
        $error("jtgng_vtimer: VS_START+VS_LEN must not exceed VTOTAL");
    end
    if (HACTIVE >= HTOTAL) begin : g_bad_hact
        $error("jtgng_vtimer: HACTIVE must be below HTOTAL");
    end
    if (VACTIVE >= VTOTAL) begin : g_bad_vact
        $error("jtgng_vtimer: VACTIVE must be below VTOTAL");
    end
    if (HTOTAL > 512) begin : g_bad_htot
        $error("jtgng_vtimer: HTOTAL must not exceed 512");
    end

    logic [8:0] hc, vc, hc_n, vc_n;
    logic [9:0] hx, vx;
    logic       hwrap, vwrap, fwrap, flip_l;

    always_comb begin
        hwrap = ({1'b0, hc} == H_LAST);
        vwrap = ({1'b0, vc} == V_LAST);
        fwrap = hwrap & vwrap;
        hc_n  = hwrap ? '0 : hc + 9'd1;
        vc_n  = vc;
        if (hwrap) begin
            vc_n = vwrap ? '0 : vc + 9'd1;
        end
        hx = {1'b0, hc_n};
        vx = {1'b0, vc_n};
    end

    // Strobes decode the next counter values so they line up with hc/vc
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hc     <= '0;
            vc     <= '0;
            flip_l <= 1'b0;
            LHBL   <= 1'b1;
            LVBL   <= 1'b1;
            HS     <= 1'b1;
            VS     <= 1'b1;
            hinit  <= 1'b0;
            vinit  <= 1'b0;
            frame  <= 1'b0;
        end else if (cen6) begin
            hc    <= hc_n;
            vc    <= vc_n;
            LHBL  <= (hx < H_ACT);
            LVBL  <= (vx < V_ACT);
            HS    <= !((hx >= HS_BEG) && (hx < HS_END));
            VS    <= !((vx >= VS_BEG) && (vx < VS_END));
            hinit <= (hx == H_LAST);
            vinit <= (hx == H_LAST) && (vx == V_LAST);
            if (fwrap) begin
                flip_l <= flip;
                frame  <= ~frame;
            end
        end
    end

    assign H = {hc[8], hc[7:0] ^ {8{flip_l}}};
    assign V = {vc[8], vc[7:0] ^ {8{flip_l}}};

endmodule

// File: tb/tb_jtgng_vtimer.sv
// Directed bench for jtgng_vtimer: default-timing instance (a) for line checks,
// short-line instance (b) so whole frames and the flip/VS corners stay cheap.
module tb_jtgng_vtimer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cen6 = 1'b0;
    logic flip = 1'b0;

    logic [8:0] ha, va, hb, vb;
    logic lhbl_a, lvbl_a, hs_a, vs_a, hinit_a, vinit_a, frame_a;
    logic lhbl_b, lvbl_b, hs_b, vs_b, hinit_b, vinit_b, frame_b;

    always #5 clk = ~clk;

    jtgng_vtimer dut_a (
        .clk(clk), .rst_n(rst_n), .cen6(cen6), .flip(flip),
        .H(ha), .V(va), .LHBL(lhbl_a), .LVBL(lvbl_a), .HS(hs_a), .VS(vs_a),
        .hinit(hinit_a), .vinit(vinit_a), .frame(frame_a)
    );

    jtgng_vtimer #(
        .HACTIVE(16), .HTOTAL(24), .HS_START(18), .HS_LEN(3),
        .VACTIVE(224), .VTOTAL(262), .VS_START(240), .VS_LEN(4)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .cen6(cen6), .flip(flip),
        .H(hb), .V(vb), .LHBL(lhbl_b), .LVBL(lvbl_b), .HS(hs_b), .VS(vs_b),
        .hinit(hinit_b), .vinit(vinit_b), .frame(frame_b)
    );

    typedef struct {
        int unsigned p;
        bit          b;
        logic [8:0]  h;
        logic [8:0]  v;
        logic [6:0]  st;   // {LHBL,LVBL,HS,VS,hinit,vinit,frame}
    } vec_t;

    vec_t        tbl[27];
    int unsigned total = 0;
    int unsigned bad = 0;
    int unsigned p = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic pulses(input int unsigned n, input bit slow);
        if (slow) begin
            for (int unsigned i = 0; i < n; i++) begin
                @(negedge clk) cen6 = 1'b1;
                @(negedge clk) cen6 = 1'b0;
                repeat (2) @(negedge clk);
            end
        end else if (n > 0) begin
            cen6 = 1'b1;
            repeat (n) @(negedge clk);
            cen6 = 1'b0;
        end
        p += n;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        cen6  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        p = 0;
    endtask

    int unsigned ha_err, lhbl_lo, hin_a, hin_pos_bad;
    int unsigned hs_lo, lvbl_lo, vs_lo, hin_b, vin_b, frm_tog, hold_err;
    logic        frm_prev;

    initial begin
        tbl[0]  = '{0,    0, 9'd0,   9'd0,   7'b1111000};
        tbl[1]  = '{0,    1, 9'd0,   9'd0,   7'b1111000};
        tbl[2]  = '{1,    0, 9'd1,   9'd0,   7'b1111000};
        tbl[3]  = '{15,   1, 9'd15,  9'd0,   7'b1111000};
        tbl[4]  = '{16,   1, 9'd16,  9'd0,   7'b0111000};
        tbl[5]  = '{18,   1, 9'd18,  9'd0,   7'b0101000};
        tbl[6]  = '{20,   1, 9'd20,  9'd0,   7'b0101000};
        tbl[7]  = '{21,   1, 9'd21,  9'd0,   7'b0111000};
        tbl[8]  = '{23,   1, 9'd23,  9'd0,   7'b0111100};
        tbl[9]  = '{24,   1, 9'd0,   9'd1,   7'b1111000};
        tbl[10] = '{255,  0, 9'd255, 9'd0,   7'b1111000};
        tbl[11] = '{256,  0, 9'd256, 9'd0,   7'b0111000};
        tbl[12] = '{287,  0, 9'd287, 9'd0,   7'b0111000};
        tbl[13] = '{288,  0, 9'd288, 9'd0,   7'b0101000};
        tbl[14] = '{319,  0, 9'd319, 9'd0,   7'b0101000};
        tbl[15] = '{320,  0, 9'd320, 9'd0,   7'b0111000};
        tbl[16] = '{383,  0, 9'd383, 9'd0,   7'b0111100};
        tbl[17] = '{384,  0, 9'd0,   9'd1,   7'b1111000};
        tbl[18] = '{5352, 1, 9'd0,   9'd223, 7'b1111000};
        tbl[19] = '{5376, 1, 9'd0,   9'd224, 7'b1011000};
        tbl[20] = '{5759, 1, 9'd23,  9'd239, 7'b0011100};
        tbl[21] = '{5760, 1, 9'd0,   9'd240, 7'b1010000};
        tbl[22] = '{5855, 1, 9'd23,  9'd243, 7'b0010100};
        tbl[23] = '{5856, 1, 9'd0,   9'd244, 7'b1011000};
        tbl[24] = '{6287, 1, 9'd23,  9'd261, 7'b0011110};
        tbl[25] = '{6288, 1, 9'd0,   9'd0,   7'b1111001};
        tbl[26] = '{6289, 1, 9'd1,   9'd0,   7'b1111001};

        // Table sweep: short gaps use the 1-in-4 enable, long gaps hold cen6 high
        do_reset();
        for (int i = 0; i < 27; i++) begin
            int unsigned adv;
            adv = tbl[i].p - p;
            pulses(adv, adv <= 64);
            if (tbl[i].b) begin
                check($sformatf("b_H[%0d]", i), 32'(hb), 32'(tbl[i].h));
                check($sformatf("b_V[%0d]", i), 32'(vb), 32'(tbl[i].v));
                check($sformatf("b_st[%0d]", i),
                      32'({lhbl_b, lvbl_b, hs_b, vs_b, hinit_b, vinit_b, frame_b}), 32'(tbl[i].st));
            end else begin
                check($sformatf("a_H[%0d]", i), 32'(ha), 32'(tbl[i].h));
                check($sformatf("a_V[%0d]", i), 32'(va), 32'(tbl[i].v));
                check($sformatf("a_st[%0d]", i),
                      32'({lhbl_a, lvbl_a, hs_a, vs_a, hinit_a, vinit_a, frame_a}), 32'(tbl[i].st));
            end
        end

        // Pixel-by-pixel frame on b, first line on a, with occupancy counts
        do_reset();
        ha_err = 0; lhbl_lo = 0; hin_a = 0; hin_pos_bad = 0;
        hs_lo = 0; lvbl_lo = 0; vs_lo = 0; hin_b = 0; vin_b = 0; frm_tog = 0;
        frm_prev = frame_b;
        for (int unsigned i = 1; i <= 6288; i++) begin
            pulses(1, i <= 384);
            if (i <= 384) begin
                if (ha != 9'(i % 384) || va != 9'(i / 384)) ha_err++;
                if (!lhbl_a) lhbl_lo++;
                if (hinit_a) begin
                    hin_a++;
                    if (ha != 9'd383) hin_pos_bad++;
                end
            end
            if (!hs_b) hs_lo++;
            if (!lvbl_b) lvbl_lo++;
            if (!vs_b) vs_lo++;
            if (hinit_b) hin_b++;
            if (vinit_b) vin_b++;
            if (frame_b != frm_prev) frm_tog++;
            frm_prev = frame_b;
        end
        check("a_hseq_err", ha_err, 0);
        check("a_lhbl_low", lhbl_lo, 128);
        check("a_hinit_cnt", hin_a, 1);
        check("a_hinit_pos", hin_pos_bad, 0);
        check("b_hs_low", hs_lo, 3 * 262);
        check("b_lvbl_low", lvbl_lo, 38 * 24);
        check("b_vs_low", vs_lo, 4 * 24);
        check("b_lines", hin_b, 262);
        check("b_vinit_cnt", vin_b, 1);
        check("b_frame_tog", frm_tog, 1);

        // Enable held low mid-line
        do_reset();
        pulses(150, 1);
        check("hold_H_pre", 32'(ha), 150);
        hold_err = 0;
        for (int unsigned i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ha != 9'd150 || va != 9'd0 || !lhbl_a || !hs_a || !lvbl_a || !vs_a || hinit_a
                || hb != 9'd6 || vb != 9'd6) hold_err++;
        end
        check("hold_err", hold_err, 0);
        pulses(1, 1);
        check("hold_H_post", 32'(ha), 151);

        // Flip request mid-frame takes effect at the frame wrap
        do_reset();
        pulses(2400, 0);
        check("flip_V100", 32'(vb), 100);
        flip = 1'b1;
        pulses(6287 - p, 0);
        check("flip_H_pre", 32'(hb), 23);
        check("flip_V_pre", 32'(vb), 32'h105);
        pulses(1, 1);
        check("flip_V0", 32'(vb), 32'h0FF);
        check("flip_H0", 32'(hb), 32'h0FF);
        pulses(5, 1);
        check("flip_H5", 32'(hb), 32'h0FA);
        check("flip_a_unflipped", 32'(ha), 149);

        // Asynchronous reset inside HS and VS of the second frame
        pulses(12091 - p, 0);
        check("rst_pre_sync", 32'({hs_b, vs_b, frame_b}), 32'b001);
        check("rst_pre_H", 32'(hb), 32'h0EC);
        check("rst_pre_V", 32'(vb), 32'h00E);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_sync", 32'({hs_b, vs_b}), 32'b11);
        check("rst_async_HV", 32'({hb, vb}), 0);
        check("rst_async_frame", 32'(frame_b), 0);
        @(negedge clk) rst_n = 1'b1;
        p = 0;
        check("rst_rel_HV", 32'({ha, va, hb, vb}), 0);
        pulses(1, 1);
        check("rst_first_H", 32'(hb), 1);

        // V=256 in the flipped frame; flip lowered mid-frame changes nothing
        pulses(6288 - p, 0);
        pulses(2400, 0);
        flip = 1'b0;
        pulses(12432 - p, 0);
        check("flip_V256", 32'(vb), 32'h1FF);
        check("flip_V256_H", 32'(hb), 32'h0FF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
